// File: rtl/vector_pkg.sv
// Shared constants and types for the vector store path.
package vector_pkg;

    localparam int unsigned S         = 32;
    localparam int unsigned LANES     = 6;
    localparam int unsigned V         = LANES * S;
    localparam int unsigned ADDR_STEP = 4;
    localparam int unsigned IDX_W     = $clog2(LANES);

    typedef logic [S-1:0]     lane_t;
    typedef logic [IDX_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } vst_state_t;

endpackage

// File: rtl/vstore_next_lane.sv
// Priority finder: lowest enabled lane at or after from_idx, with a flag when none remain.
module vstore_next_lane
    import vector_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  lane_idx_t        from_idx,
    output lane_idx_t        next_idx,
    output logic             none_left
);

    // Scanning from the top down lets the lowest qualifying lane win.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from_idx))) begin
                next_idx  = lane_idx_t'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_store_unit.sv
// Captures a 6-lane vector and serializes it onto a 32-bit write port.
// Optional lane skipping is enabled by defining VSTORE_MASK_EN.
module vector_store_unit
    import vector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [V-1:0]     data_in,
`ifdef VSTORE_MASK_EN
    input  logic [LANES-1:0] lane_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [S-1:0]     mem_wdata,
    input  logic             mem_ready
);

    vst_state_t       state_q, state_d;
    lane_idx_t        idx_q, idx_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [31:0]      base_q, base_d;
    logic [V-1:0]     data_q, data_d;

    logic [LANES-1:0] mask_in;
    logic [LANES-1:0] find_mask;
    lane_idx_t        find_from;
    lane_idx_t        find_next;
    logic             find_none;

`ifdef VSTORE_MASK_EN
    assign mask_in = lane_mask;
`else
    assign mask_in = '1;
`endif

    vstore_next_lane u_next_lane (
        .mask      (find_mask),
        .from_idx  (find_from),
        .next_idx  (find_next),
        .none_left (find_none)
    );

    // In IDLE the finder looks at the incoming mask from lane 0; in WRITE it
    // looks past the current lane so the following beat is ready on acceptance.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        base_d    = base_q;
        data_d    = data_q;
        find_mask = mask_q;
        find_from = lane_idx_t'(idx_q + lane_idx_t'(1));

        case (state_q)
            IDLE: begin
                find_mask = mask_in;
                find_from = '0;
                if (start) begin
                    data_d  = data_in;
                    base_d  = base_addr;
                    mask_d  = mask_in;
                    idx_d   = find_next;
                    state_d = find_none ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (find_none) begin
                        state_d = DONE;
                    end else begin
                        idx_d = find_next;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    // Payload registers carry no reset; the bus outputs are gated by state.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        data_q <= data_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_we ? (base_q + 32'(idx_q) * ADDR_STEP) : 32'd0;
    assign mem_wdata = mem_we ? data_q[int'(idx_q) * S +: S] : '0;

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit with a beat scoreboard on the write port.
module tb_vector_store_unit;
    import vector_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [V-1:0]     data_in = '0;
    logic [LANES-1:0] lane_mask = '1;
    logic             mem_ready = 1'b1;
    logic             busy, done, mem_we;
    logic [31:0]      mem_addr;
    logic [S-1:0]     mem_wdata;

    int    errors = 0;
    int    checks = 0;
    int    beats  = 0;
    int    b0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    vector_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .data_in   (data_in),
`ifdef VSTORE_MASK_EN
        .lane_mask (lane_mask),
`endif
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [V-1:0] vec_of(input logic [31:0] k);
        logic [V-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*S +: S] = 32'(k * 32'(i + 1));
        end
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] base, input logic [V-1:0] data,
                            input logic [LANES-1:0] mask, input int npush);
        beat_t b;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] && i < npush) begin
                b.addr = base + 32'(i) * 32'd4;
                b.data = data[i*S +: S];
                exp_q.push_back(b);
            end
        end
    endtask

    // Drives start for one cycle, then scrambles the inputs it no longer cares about.
    task automatic start_store(input logic [31:0] base, input logic [V-1:0] data,
                               input logic [LANES-1:0] mask, input int npush);
        push_exp(base, data, mask, npush);
        base_addr = base;
        data_in   = data;
        lane_mask = mask;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = ~base;
        data_in   = ~data;
        lane_mask = ~mask;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
        tick();
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_addr", 64'(mem_addr), 64'hFFFF_FFFF_0000_0000);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_addr", 64'(mem_addr), 64'(e.addr));
                chk("beat_data", 64'(mem_wdata), 64'(e.data));
                beats++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // Basic store, ready tied high
        start_store(32'h1000, vec_of(32'h1111_1111), '1, 6);
        for (int k = 0; k < 6; k++) begin
            chk("basic_we", 64'(mem_we), 64'd1);
            chk("basic_busy", 64'(busy), 64'd1);
            chk("basic_addr", 64'(mem_addr), 64'(32'h1000 + 32'(4 * k)));
            tick();
        end
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_done_busy", 64'(busy), 64'd1);
        chk("basic_done_we", 64'(mem_we), 64'd0);
        tick();
        chk("basic_after_done", 64'(done), 64'd0);
        chk("basic_after_busy", 64'(busy), 64'd0);
        chk("basic_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure on lane 2
        b0 = beats;
        start_store(32'h1000, vec_of(32'h1111_1111), '1, 6);
        tick();
        tick();
        for (int h = 0; h < 4; h++) begin
            mem_ready = (h == 3);
            chk("bp_we", 64'(mem_we), 64'd1);
            chk("bp_addr", 64'(mem_addr), 64'h1008);
            chk("bp_data", 64'(mem_wdata), 64'h3333_3333);
            tick();
        end
        tick();
        tick();
        tick();
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_beats", 64'(beats - b0), 64'd6);
        tick();

        // Start while busy and in DONE is ignored; start after done is taken
        start_store(32'h2000, vec_of(32'h0102_0304), '1, 6);
        tick();
        tick();
        start     = 1'b1;
        base_addr = 32'h3000;
        data_in   = vec_of(32'hDEAD_BEEF);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rs_done", 64'(done), 64'd1);
        start     = 1'b1;
        base_addr = 32'h4000;
        data_in   = vec_of(32'h0A0B_0C0D);
        tick();
        chk("rs_done_start_ignored_we", 64'(mem_we), 64'd0);
        chk("rs_done_start_ignored_busy", 64'(busy), 64'd0);
        push_exp(32'h4000, vec_of(32'h0A0B_0C0D), '1, 6);
        tick();
        start = 1'b0;
        chk("rs_new_we", 64'(mem_we), 64'd1);
        chk("rs_new_addr", 64'(mem_addr), 64'h4000);
        wait_done("rs_new_done", 20);
        chk("rs_drained", 64'(exp_q.size()), 64'd0);

        // Reset abort at lane 3
        start_store(32'h5000, vec_of(32'h1020_3040), '1, 4);
        tick();
        tick();
        tick();
        chk("abort_lane3_addr", 64'(mem_addr), 64'h500C);
        rst = 1'b1;
        tick();
        chk("abort_we", 64'(mem_we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_more_beats", 64'(exp_q.size()), 64'd0);
        start_store(32'h6000, vec_of(32'h5A5A_5A5A), '1, 6);
        wait_done("abort_restart_done", 20);
        chk("abort_restart_drained", 64'(exp_q.size()), 64'd0);

        // Address wrap
        start_store(32'hFFFF_FFF8, vec_of(32'h7777_7777), '1, 6);
        chk("wrap_a0", 64'(mem_addr), 64'hFFFF_FFF8);
        tick();
        chk("wrap_a1", 64'(mem_addr), 64'hFFFF_FFFC);
        tick();
        chk("wrap_a2", 64'(mem_addr), 64'h0);
        tick();
        chk("wrap_a3", 64'(mem_addr), 64'h4);
        wait_done("wrap_done", 20);
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);

`ifdef VSTORE_MASK_EN
        // Sparse mask and empty mask
        start_store(32'h1000, vec_of(32'h1111_1111), 6'b100101, 6);
        chk("mask_a0", 64'(mem_addr), 64'h1000);
        tick();
        chk("mask_a2", 64'(mem_addr), 64'h1008);
        chk("mask_d2", 64'(mem_wdata), 64'h3333_3333);
        tick();
        chk("mask_a5", 64'(mem_addr), 64'h1014);
        chk("mask_d5", 64'(mem_wdata), 64'h6666_6666);
        tick();
        chk("mask_done", 64'(done), 64'd1);
        chk("mask_done_we", 64'(mem_we), 64'd0);
        tick();
        start_store(32'h1000, vec_of(32'h1111_1111), 6'b000000, 6);
        chk("mask0_done", 64'(done), 64'd1);
        chk("mask0_we", 64'(mem_we), 64'd0);
        tick();
        chk("mask0_after", 64'(done), 64'd0);
        chk("mask_drained", 64'(exp_q.size()), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
